fault_class_latch: RTL

- Upstream feeder of the health-LED blink-code generator.
- Debounces raw power/board fault lines, grouped 11 classes × CLASS_SIZE bits (class 0 … class A), and latches them sticky into per-class vectors that drive the generator's class_0..class_A inputs.
- Records the first class to fault.
- Provides a req/ack clear handshake for BMC/firmware, with a post-clear blanking window.

---
 rtl/fault_class_latch_pkg.sv | 38 +++
 rtl/fault_debounce_bit.sv | 42 ++++
 rtl/fault_class_latch.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fault_class_latch_pkg.sv
// Shared types and constants for the fault class latch: FSM encoding, class indices, width helper.
package fault_class_latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FAULTED = 2'd2,
    ST_BLANK   = 2'd3
  } state_t;

  localparam int NUM_CLASSES = 11;

  localparam logic [3:0] CLASS_0 = 4'd0;
  localparam logic [3:0] CLASS_1 = 4'd1;
  localparam logic [3:0] CLASS_2 = 4'd2;
  localparam logic [3:0] CLASS_3 = 4'd3;
  localparam logic [3:0] CLASS_4 = 4'd4;
  localparam logic [3:0] CLASS_5 = 4'd5;
  localparam logic [3:0] CLASS_6 = 4'd6;
  localparam logic [3:0] CLASS_7 = 4'd7;
  localparam logic [3:0] CLASS_8 = 4'd8;
  localparam logic [3:0] CLASS_9 = 4'd9;
  localparam logic [3:0] CLASS_A = 4'd10;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fault_debounce_bit.sv
// One fault line: saturating run-length counter feeding a sticky latch.
// Latch sets the edge after the counter reaches DEBOUNCE_CYCLES; clr has priority over set.
module fault_debounce_bit
  import fault_class_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic cnt_en,
  input  logic raw,
  input  logic clr,
  output logic hit,
  output logic latched
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  assign hit = (cnt == CNT_MAX);

  always_ff @(posedge sys_clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt_en && raw) begin
      cnt <= hit ? CNT_MAX : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset || clr) begin
      latched <= 1'b0;
    end else if (hit) begin
      latched <= 1'b1;
    end
  end

endmodule

// File: rtl/fault_class_latch.sv
// Debounces 11 classes of raw fault lines into sticky per-class vectors, tracks the first class to fault,
// and runs a req/ack clear with a blanking window that waits for all unmasked raw faults to stay low.
module fault_class_latch
  import fault_class_latch_pkg::*;
#(
  parameter int CLASS_SIZE      = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLANK_CYCLES    = 16
) (
  input  logic                              sys_clk,
  input  logic                              reset,
  input  logic [NUM_CLASSES*CLASS_SIZE-1:0] fault_raw,
  input  logic [NUM_CLASSES*CLASS_SIZE-1:0] fault_mask,
  input  logic                              arm,
  input  logic                              clear_req,
  output logic                              clear_ack,
  output logic [CLASS_SIZE-1:0]             class_0,
  output logic [CLASS_SIZE-1:0]             class_1,
  output logic [CLASS_SIZE-1:0]             class_2,
  output logic [CLASS_SIZE-1:0]             class_3,
  output logic [CLASS_SIZE-1:0]             class_4,
  output logic [CLASS_SIZE-1:0]             class_5,
  output logic [CLASS_SIZE-1:0]             class_6,
  output logic [CLASS_SIZE-1:0]             class_7,
  output logic [CLASS_SIZE-1:0]             class_8,
  output logic [CLASS_SIZE-1:0]             class_9,
  output logic [CLASS_SIZE-1:0]             class_A,
  output logic                              any_fault,
  output logic [3:0]                        first_class,
  output logic                              first_valid,
  output logic [1:0]                        state_o
);

  localparam int NB = NUM_CLASSES * CLASS_SIZE;
  localparam int BW = clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   cap_en;
  logic                   clr;
  logic                   ack_nxt;
  logic                   raw_clean;
  logic [BW-1:0]          blank_cnt;
  logic [NB-1:0]          hit;
  logic [NB-1:0]          latched;
  logic [NUM_CLASSES-1:0] class_hit;
  logic [3:0]             hi_cls;

  assign cap_en    = (state == ST_ARMED) || (state == ST_FAULTED);
  assign raw_clean = ~|(fault_raw & ~fault_mask);

  for (genvar b = 0; b < NB; b++) begin : gen_bit
    fault_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .sys_clk (sys_clk),
      .reset   (reset),
      .cnt_en  (cap_en & ~fault_mask[b]),
      .raw     (fault_raw[b]),
      .clr     (clr),
      .hit     (hit[b]),
      .latched (latched[b])
    );
  end

  // Highest class index wins when several classes latch together, matching blink priority.
  always_comb begin
    hi_cls = CLASS_0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      class_hit[k] = |hit[k*CLASS_SIZE +: CLASS_SIZE];
      if (class_hit[k]) hi_cls = 4'(k);
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    ack_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) state_nxt = any_fault ? ST_FAULTED : ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm)            state_nxt = ST_IDLE;
        else if (|class_hit) state_nxt = ST_FAULTED;
      end
      ST_FAULTED: begin
        if (!arm) begin
          state_nxt = ST_IDLE;
        end else if (clear_req) begin
          state_nxt = ST_BLANK;
          clr       = 1'b1;
        end
      end
      ST_BLANK: begin
        if (raw_clean && (blank_cnt == BLANK_LAST)) begin
          ack_nxt   = 1'b1;
          state_nxt = arm ? ST_ARMED : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      clear_ack <= 1'b0;
    end else begin
      state     <= state_nxt;
      clear_ack <= ack_nxt;
    end
  end

  // Counts consecutive clean cycles; any unmasked raw fault restarts the window.
  always_ff @(posedge sys_clk) begin
    if (reset || (state != ST_BLANK) || !raw_clean) begin
      blank_cnt <= '0;
    end else begin
      blank_cnt <= blank_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset || clr) begin
      first_valid <= 1'b0;
      first_class <= CLASS_0;
    end else if (!first_valid && (|class_hit)) begin
      first_valid <= 1'b1;
      first_class <= hi_cls;
    end
  end

  assign any_fault = |latched;
  assign state_o   = state;

  assign class_0 = latched[0*CLASS_SIZE +: CLASS_SIZE];
  assign class_1 = latched[1*CLASS_SIZE +: CLASS_SIZE];
  assign class_2 = latched[2*CLASS_SIZE +: CLASS_SIZE];
  assign class_3 = latched[3*CLASS_SIZE +: CLASS_SIZE];
  assign class_4 = latched[4*CLASS_SIZE +: CLASS_SIZE];
  assign class_5 = latched[5*CLASS_SIZE +: CLASS_SIZE];
  assign class_6 = latched[6*CLASS_SIZE +: CLASS_SIZE];
  assign class_7 = latched[7*CLASS_SIZE +: CLASS_SIZE];
  assign class_8 = latched[8*CLASS_SIZE +: CLASS_SIZE];
  assign class_9 = latched[9*CLASS_SIZE +: CLASS_SIZE];
  assign class_A = latched[10*CLASS_SIZE +: CLASS_SIZE];

endmodule
